// File: rtl/dpram_fifo_ctrl_if.sv
// Purpose: valid/ready handshake bundle for the FIFO write (s_*) and read (m_*) sides.
//  slave  : FIFO side (accepts s_*, produces m_*)
//  master : environment side (produces s_*, accepts m_*)
interface dpram_fifo_ctrl_if #(
    parameter int unsigned DATA_WIDTH = 32
) ();
    logic [DATA_WIDTH-1:0] s_data;
    logic                  s_valid;
    logic                  s_ready;
    logic [DATA_WIDTH-1:0] m_data;
    logic                  m_valid;
    logic                  m_ready;

    modport slave (
        input  s_data,
        input  s_valid,
        output s_ready,
        output m_data,
        output m_valid,
        input  m_ready
    );

    modport master (
        output s_data,
        output s_valid,
        input  s_ready,
        input  m_data,
        input  m_valid,
        output m_ready
    );
endinterface

// File: rtl/dpram_fifo_ctrl.sv
// Purpose: first-word-fall-through FIFO controller around a single-clock dual-port RAM.
//  The RAM read register doubles as the output stage (m_data), so no extra data flops.
// Ports:
//  clk, rst   : clock, synchronous active-high reset
//  flush      : synchronous clear, same effect as rst
//  bus        : s_data/s_valid/s_ready write side, m_data/m_valid/m_ready read side
//  count      : occupancy = RAM entries + m_valid (capacity 2**DEPTH_LOG2 + 1)
//  empty/full : registered occupancy flags
module dpram_fifo_ctrl #(
    parameter int unsigned DEPTH_LOG2 = 2,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    dpram_fifo_ctrl_if.slave      bus,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  empty,
    output logic                  full
);
    localparam int unsigned PTR_W     = DEPTH_LOG2 + 1;
    localparam int unsigned RAM_DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned CAPACITY  = RAM_DEPTH + 1;

    logic [DATA_WIDTH-1:0] ram_q [RAM_DEPTH];
    logic [DATA_WIDTH-1:0] rdata_q;

    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic [PTR_W-1:0] count_q, count_d;
    logic             m_valid_q, m_valid_d;
    logic             empty_q, empty_d;
    logic             full_q, full_d;

    logic ram_empty_c, ram_full_c;
    logic push_c, fetch_c, pop_c;
    logic clear_c;
    logic ram_we_c, ram_re_c;

    // Pointer-derived RAM status; MSB is the wrap bit.
    assign ram_empty_c = (wptr_q == rptr_q);
    assign ram_full_c  = (wptr_q[DEPTH_LOG2] != rptr_q[DEPTH_LOG2]) &&
                         (wptr_q[DEPTH_LOG2-1:0] == rptr_q[DEPTH_LOG2-1:0]);

    assign clear_c = rst || flush;
    assign push_c  = bus.s_valid && !ram_full_c;
    // Refill the output stage whenever it is empty or being consumed this cycle.
    assign fetch_c = !ram_empty_c && (!m_valid_q || bus.m_ready);
    assign pop_c   = m_valid_q && bus.m_ready;

    assign ram_we_c = push_c && !clear_c;
    assign ram_re_c = fetch_c && !clear_c;

    // Next-state for pointers, output-stage valid and occupancy.
    always_comb begin
        wptr_d    = wptr_q;
        rptr_d    = rptr_q;
        m_valid_d = m_valid_q;
        count_d   = count_q;
        if (push_c) begin
            wptr_d = wptr_q + PTR_W'(1);
        end
        if (fetch_c) begin
            rptr_d    = rptr_q + PTR_W'(1);
            m_valid_d = 1'b1;
        end else if (pop_c) begin
            m_valid_d = 1'b0;
        end
        case ({push_c, pop_c})
            2'b10:   count_d = count_q + PTR_W'(1);
            2'b01:   count_d = count_q - PTR_W'(1);
            default: count_d = count_q;
        endcase
        empty_d = (count_d == PTR_W'(0));
        full_d  = (count_d == PTR_W'(CAPACITY));
    end

    // Control state registers.
    always_ff @(posedge clk) begin
        if (clear_c) begin
            wptr_q    <= '0;
            rptr_q    <= '0;
            m_valid_q <= 1'b0;
            count_q   <= '0;
            empty_q   <= 1'b1;
            full_q    <= 1'b0;
        end else begin
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            m_valid_q <= m_valid_d;
            count_q   <= count_d;
            empty_q   <= empty_d;
            full_q    <= full_d;
        end
    end

    // Dual-port RAM with registered read; re held low keeps m_data stable under backpressure.
    // A read never targets the slot being written (needs !ram_empty vs !ram_full), so no bypass.
    always_ff @(posedge clk) begin
        if (ram_we_c) begin
            ram_q[wptr_q[DEPTH_LOG2-1:0]] <= bus.s_data;
        end
        if (ram_re_c) begin
            rdata_q <= ram_q[rptr_q[DEPTH_LOG2-1:0]];
        end
    end

    assign bus.s_ready = !ram_full_c;
    assign bus.m_data  = rdata_q;
    assign bus.m_valid = m_valid_q;
    assign count       = count_q;
    assign empty       = empty_q;
    assign full        = full_q;
endmodule

// File: tb/tb_dpram_fifo_ctrl.sv
// Purpose: self-checking bench for dpram_fifo_ctrl (DEPTH_LOG2=2, DATA_WIDTH=8).
//  Scenario tasks check flags/latency inline; a negedge scoreboard checks data order.
module tb_dpram_fifo_ctrl;
    logic       clk;
    logic       rst;
    logic       flush;
    logic [2:0] count;
    logic       empty;
    logic       full;

    int checks;
    int errors;
    logic [7:0] sb_q[$];

    dpram_fifo_ctrl_if #(.DATA_WIDTH(8)) bus ();

    dpram_fifo_ctrl #(.DEPTH_LOG2(2), .DATA_WIDTH(8)) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus),
        .count (count),
        .empty (empty),
        .full  (full)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Scoreboard: decisions sampled at negedge reflect what the next posedge does.
    always @(negedge clk) begin
        logic [7:0] exp;
        if (rst || flush) begin
            sb_q.delete();
        end else begin
            if (bus.m_valid === 1'b1 && bus.m_ready === 1'b1) begin
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected: got 0x%02h with empty scoreboard", bus.m_data);
                end else begin
                    exp = sb_q.pop_front();
                    if (bus.m_data !== exp) begin
                        errors++;
                        $display("FAIL sb_order: got 0x%02h expected 0x%02h", bus.m_data, exp);
                    end
                end
            end
            if (bus.s_valid === 1'b1 && bus.s_ready === 1'b1) sb_q.push_back(bus.s_data);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.s_valid = 1'b0;
        bus.m_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (count !== 3'd0 || empty !== 1'b1 || full !== 1'b0 ||
            bus.s_ready !== 1'b1 || bus.m_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: count=%0d empty=%b full=%b s_ready=%b m_valid=%b expected 0 1 0 1 0",
                     count, empty, full, bus.s_ready, bus.m_valid);
        end
    endtask

    task automatic test_single_push();
        do_reset();
        bus.s_data  = 8'hA1;
        bus.s_valid = 1'b1;
        bus.m_ready = 1'b0;
        tick();
        bus.s_valid = 1'b0;
        checks++;
        if (count !== 3'd1 || bus.m_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_n1: count=%0d m_valid=%b expected 1 0", count, bus.m_valid);
        end
        tick();
        checks++;
        if (count !== 3'd1 || bus.m_valid !== 1'b1 || bus.m_data !== 8'hA1) begin
            errors++;
            $display("FAIL single_n2: count=%0d m_valid=%b m_data=0x%02h expected 1 1 0xa1",
                     count, bus.m_valid, bus.m_data);
        end
    endtask

    task automatic test_fill();
        int accepted;
        do_reset();
        accepted = 0;
        bus.m_ready = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            bus.s_data  = 8'(i);
            bus.s_valid = 1'b1;
            if (bus.s_ready) accepted++;
            tick();
        end
        checks++;
        if (accepted != 5) begin
            errors++;
            $display("FAIL fill_accepted: got %0d expected 5", accepted);
        end
        checks++;
        if (bus.s_ready !== 1'b0 || full !== 1'b1 || count !== 3'd5 || empty !== 1'b0) begin
            errors++;
            $display("FAIL fill_flags: s_ready=%b full=%b count=%0d empty=%b expected 0 1 5 0",
                     bus.s_ready, full, count, empty);
        end
        bus.s_valid = 1'b0;
    endtask

    task automatic test_drain();
        bus.m_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (bus.m_valid !== 1'b1 || bus.m_data !== 8'(i + 1)) begin
                errors++;
                $display("FAIL drain_word%0d: m_valid=%b m_data=0x%02h expected 1 0x%02h",
                         i, bus.m_valid, bus.m_data, 8'(i + 1));
            end
            tick();
        end
        checks++;
        if (empty !== 1'b1 || bus.m_valid !== 1'b0 || count !== 3'd0) begin
            errors++;
            $display("FAIL drain_end: empty=%b m_valid=%b count=%0d expected 1 0 0",
                     empty, bus.m_valid, count);
        end
        bus.m_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        do_reset();
        bus.m_ready = 1'b1;
        for (int cyc = 0; cyc < 22; cyc++) begin
            bus.s_valid = (cyc < 20);
            bus.s_data  = 8'(32'h10 + cyc);
            tick();
            if (cyc < 20) begin
                checks++;
                if (count < 3'd1 || count > 3'd2) begin
                    errors++;
                    $display("FAIL stream_count c%0d: count=%0d expected 1..2", cyc, count);
                end
            end
            if (cyc >= 1 && cyc <= 20) begin
                checks++;
                if (bus.m_valid !== 1'b1 || bus.m_data !== 8'(32'h10 + cyc - 1)) begin
                    errors++;
                    $display("FAIL stream_word c%0d: m_valid=%b m_data=0x%02h expected 1 0x%02h",
                             cyc, bus.m_valid, bus.m_data, 8'(32'h10 + cyc - 1));
                end
            end
        end
        checks++;
        if (empty !== 1'b1 || bus.m_valid !== 1'b0) begin
            errors++;
            $display("FAIL stream_end: empty=%b m_valid=%b expected 1 0", empty, bus.m_valid);
        end
        bus.m_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        int idx;
        int outn;
        logic hold;
        logic [7:0] prev;
        do_reset();
        idx  = 0;
        outn = 0;
        hold = 1'b0;
        prev = '0;
        for (int cyc = 0; cyc < 400 && outn < 16; cyc++) begin
            bus.s_valid = (idx < 16);
            bus.s_data  = 8'(32'h40 + idx);
            bus.m_ready = 1'($urandom_range(0, 1));
            if (hold) begin
                checks++;
                if (bus.m_data !== prev) begin
                    errors++;
                    $display("FAIL bp_stable c%0d: m_data=0x%02h expected 0x%02h", cyc, bus.m_data, prev);
                end
            end
            if (bus.m_valid && bus.m_ready) begin
                checks++;
                if (bus.m_data !== 8'(32'h40 + outn)) begin
                    errors++;
                    $display("FAIL bp_word%0d: m_data=0x%02h expected 0x%02h",
                             outn, bus.m_data, 8'(32'h40 + outn));
                end
                outn++;
            end
            if (bus.s_valid && bus.s_ready) idx++;
            hold = bus.m_valid && !bus.m_ready;
            prev = bus.m_data;
            tick();
        end
        checks++;
        if (outn != 16) begin
            errors++;
            $display("FAIL bp_timeout: delivered %0d expected 16", outn);
        end
        bus.s_valid = 1'b0;
        bus.m_ready = 1'b0;
    endtask

    task automatic test_clear(input bit use_flush);
        do_reset();
        bus.m_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.s_valid = 1'b1;
            bus.s_data  = 8'(32'h60 + i);
            tick();
        end
        bus.s_data = 8'h99;
        if (use_flush) flush = 1'b1;
        else           rst   = 1'b1;
        tick();
        flush = 1'b0;
        rst   = 1'b0;
        bus.s_valid = 1'b0;
        checks++;
        if (count !== 3'd0 || bus.m_valid !== 1'b0 || empty !== 1'b1) begin
            errors++;
            $display("FAIL clear_state(flush=%0d): count=%0d m_valid=%b empty=%b expected 0 0 1",
                     use_flush, count, bus.m_valid, empty);
        end
        tick();
        tick();
        checks++;
        if (count !== 3'd0 || bus.m_valid !== 1'b0) begin
            errors++;
            $display("FAIL clear_dropped(flush=%0d): count=%0d m_valid=%b expected 0 0",
                     use_flush, count, bus.m_valid);
        end
        bus.s_valid = 1'b1;
        bus.s_data  = 8'h77;
        tick();
        bus.s_valid = 1'b0;
        tick();
        checks++;
        if (bus.m_valid !== 1'b1 || bus.m_data !== 8'h77 || count !== 3'd1) begin
            errors++;
            $display("FAIL clear_reuse(flush=%0d): m_valid=%b m_data=0x%02h count=%0d expected 1 0x77 1",
                     use_flush, bus.m_valid, bus.m_data, count);
        end
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        rst         = 1'b1;
        flush       = 1'b0;
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        bus.m_ready = 1'b0;
        test_reset();
        test_single_push();
        test_fill();
        test_drain();
        test_back_to_back();
        test_backpressure();
        test_clear(1'b1);
        test_clear(1'b0);
        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
